ift_sdff_arbiter: RTL
=====================

IFT_SDFF_ARBITER -- requirements
Module: ift_sdff_arbiter

Interface
REQ-001 Parameter WIDTH, default 2, data width of the shared register and of each write lane.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter SRST_VALUE, default 2, value loaded by a synchronous clear.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 CLK  in  1  clock, rising edge active.
REQ-006 ARST  in  1  asynchronous reset, active-high.
REQ-007 CLK_t, ARST_t  in  32 each  taint tags of clock and reset; accepted, never propagated.
REQ-008 REQ  in  NREQ  per-requester write request, level.
REQ-009 REQ_t  in  32  taint tag of the REQ vector.
REQ-010 WDATA  in  NREQ*WIDTH  write lanes; lane i is bits [i*WIDTH +: WIDTH].
REQ-011 WDATA_t  in  NREQ*32  per-lane taint tags; lane i is bits [i*32 +: 32].
REQ-012 CLR, CLR_t  in  1 / 32  synchronous clear request and its taint tag.
REQ-013 GNT  out  NREQ  registered one-hot grant.
REQ-014 GNT_t  out  32  taint of the grant decision.
REQ-015 Q, Q_t  out  WIDTH / 32  shared register value and its taint tag.
REQ-016 BUSY  out  1  high while state is GRANT.

Function
REQ-017 The FSM SHALL have two states: IDLE and GRANT.
REQ-018 IDLE, CLR=1: Q <= SRST_VALUE, Q_t <= CLR_t, GNT stays 0, state stays IDLE, REQ ignored for that edge.
REQ-019 IDLE, CLR=0, REQ!=0: GNT <= one-hot of winner W, GNT_t <= REQ_t, W latched, state -> GRANT.
REQ-020 IDLE, CLR=0, REQ=0: Q, Q_t, GNT (=0), GNT_t (=0) hold; state stays IDLE.
REQ-021 Winner W SHALL be the first index i with REQ[i]=1 searching P, P+1, ... NREQ-1, 0, ... P-1, where P is the round-robin pointer.
REQ-022 GRANT, at the edge: with D = WDATA lane W and D_t = WDATA_t lane W, sampled at this edge, not the IDLE edge.
REQ-023 GRANT, CLR=0: Q <= D; Q_t <= (D == SRST_VALUE ? D_t | CLR_t : D_t) | GNT_t.
REQ-024 GRANT, CLR=1: Q <= SRST_VALUE; Q_t <= (D == SRST_VALUE ? D_t | CLR_t : CLR_t) | GNT_t.
REQ-025 If D contains any X/Z bit, Q_t SHALL be loaded with 0 regardless of REQ-023/024.
REQ-026 Every GRANT edge: GNT <= 0, GNT_t <= 0, P <= (W+1) mod NREQ, state -> IDLE; grants never occur back-to-back.
REQ-027 Withdrawal of REQ[W] during GRANT SHALL NOT cancel the write.
REQ-028 Write latency: Q updates at the second rising edge after REQ is first sampled high in IDLE.
REQ-029 P SHALL advance only on a GRANT edge; CLR in IDLE SHALL NOT move P.
REQ-030 Comparisons use WIDTH bits; SRST_VALUE is truncated to WIDTH.

Reset
REQ-031 While ARST=1, independent of CLK: Q=0, Q_t=0, GNT=0, GNT_t=0, BUSY=0, P=0, state=IDLE.
REQ-032 ARST asserted during GRANT SHALL abort the pending write; Q takes the reset value, not D.
REQ-033 First edge after ARST deasserts is evaluated as IDLE.

Structure
REQ-034 Shared package ift_arb_pkg SHALL hold the state enum (IDLE, GRANT) and TAINT_W = 32.
REQ-035 The round-robin search SHALL be the combinational sub-module ift_rr_pick (inputs: REQ, P; outputs: W and a valid flag).

Verification
REQ-036 Single requester: REQ=4'b0100, lane2=2'b01, lane2 taint=0x1, REQ_t=0 -> GNT=0100 after edge 1; Q=01, Q_t=0x1 after edge 2; P=3.
REQ-037 Round robin: REQ=4'b1111 held -> grants issued in order 0,1,2,3,0 every second edge.
REQ-038 Clear during GRANT: lane0 D=2'b10, D_t=0x4, CLR_t=0x8, GNT_t=0x10 -> Q=2, Q_t=0x1C. Repeat with D=2'b01 -> Q=2, Q_t=0x18.
REQ-039 X data: lane W = 2'bx1 in GRANT -> Q_t=0 after the edge.
REQ-040 Reset mid-operation: ARST pulsed between GRANT-entry edge and write edge -> Q=0, Q_t=0, GNT=0, P=0 immediately, no write after release.

Source files
------------

// File: rtl/ift_sdff_arbiter_pkg.sv
// Shared definitions for the taint-tracking round-robin arbiter.
//   TAINT_W     : width of every taint tag
//   state_t     : arbiter FSM state (IDLE, GRANT)
//   write_taint : taint loaded into the shared register on a GRANT edge
package ift_arb_pkg;

  localparam int TAINT_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Taint of the value written on a GRANT edge. When the lane data equals
  // the clear value, both the data and the clear could have produced the
  // result, so both tags flow. Otherwise only the source that actually
  // determined Q (clear or data) contributes. The grant decision taint
  // always flows.
  function automatic logic [TAINT_W-1:0] write_taint(
    input logic               d_is_srst,
    input logic               clr,
    input logic [TAINT_W-1:0] d_t,
    input logic [TAINT_W-1:0] clr_t,
    input logic [TAINT_W-1:0] gnt_t
  );
    logic [TAINT_W-1:0] base;
    if (d_is_srst)  base = d_t | clr_t;
    else if (clr)   base = clr_t;
    else            base = d_t;
    return base | gnt_t;
  endfunction

endpackage

// File: rtl/ift_sdff_arbiter_if.sv
// Bus bundle between requesters and the arbiter.
//   master : drives req/req_t, wdata/wdata_t, clr/clr_t; observes results
//   slave  : the arbiter; drives gnt/gnt_t, q/q_t, busy and debug state
// Handshake: req[i] is a level request. A grant (gnt one-hot, one cycle)
// is issued on the edge after req is seen in IDLE; the write of lane i
// happens on the following edge whether or not req[i] is still high.
interface ift_sdff_arbiter_if #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 4
);
  import ift_arb_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req;
  logic [TAINT_W-1:0]      req_t;
  logic [NREQ*WIDTH-1:0]   wdata;
  logic [NREQ*TAINT_W-1:0] wdata_t;
  logic                    clr;
  logic [TAINT_W-1:0]      clr_t;
  logic [NREQ-1:0]         gnt;
  logic [TAINT_W-1:0]      gnt_t;
  logic [WIDTH-1:0]        q;
  logic [TAINT_W-1:0]      q_t;
  logic                    busy;
  state_t                  dbg_state;
  logic [PW-1:0]           dbg_ptr;

  modport master (
    output req, req_t, wdata, wdata_t, clr, clr_t,
    input  gnt, gnt_t, q, q_t, busy, dbg_state, dbg_ptr
  );

  modport slave (
    input  req, req_t, wdata, wdata_t, clr, clr_t,
    output gnt, gnt_t, q, q_t, busy, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/ift_sdff_arbiter_rr_pick.sv
// Combinational round-robin search.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   win   : first requesting index searching ptr, ptr+1, ... wrapping
//   valid : at least one request is set
module ift_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            valid
);

  // Walk from the farthest offset back to offset 0 so the nearest
  // requesting index to ptr is the last assignment and therefore wins.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    valid = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) win = idx[PW-1:0];
    end
  end

endmodule

// File: rtl/ift_sdff_arbiter.sv
// Round-robin arbiter for a shared register with taint tracking.
//   clk, arst      : clock (rising edge), asynchronous active-high reset
//   clk_t, arst_t  : taint tags of clock/reset, accepted but not propagated
//   bus (slave)    : requests, write lanes, clear, grant and register outputs
// Two-state FSM: IDLE picks a winner and issues a one-cycle grant; GRANT
// writes the winner's lane (sampled at the GRANT edge) and returns to IDLE,
// so grants never occur back to back.
module ift_sdff_arbiter
  import ift_arb_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int NREQ       = 4,
  parameter int SRST_VALUE = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [TAINT_W-1:0] clk_t,
  input  logic [TAINT_W-1:0] arst_t,
  ift_sdff_arbiter_if.slave  bus
);

  localparam int               PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] SRST_W = WIDTH'(SRST_VALUE);

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      win;
  logic [NREQ-1:0]    gnt;
  logic [TAINT_W-1:0] gnt_t;
  logic [WIDTH-1:0]   q;
  logic [TAINT_W-1:0] q_t;
  logic               busy;

  logic [PW-1:0]      pick_win;
  logic               pick_valid;
  logic [WIDTH-1:0]   d;
  logic [TAINT_W-1:0] d_t;
  logic               d_unknown;

  // Clock/reset taints are intentionally dropped.
  logic unused_taint;
  assign unused_taint = ^{clk_t, arst_t};

  ift_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Lane of the latched winner, read live so the GRANT edge samples it.
  always_comb begin
    d         = bus.wdata[int'(win)*WIDTH +: WIDTH];
    d_t       = bus.wdata_t[int'(win)*TAINT_W +: TAINT_W];
    d_unknown = $isunknown(d);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      gnt   <= '0;
      gnt_t <= '0;
      q     <= '0;
      q_t   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr) begin
            // Clear wins over requests and does not move the pointer.
            q   <= SRST_W;
            q_t <= bus.clr_t;
          end else if (pick_valid) begin
            gnt   <= NREQ'(1) << pick_win;
            gnt_t <= bus.req_t;
            win   <= pick_win;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          q <= bus.clr ? SRST_W : d;
          if (d_unknown) q_t <= '0;
          else           q_t <= write_taint(d == SRST_W, bus.clr, d_t, bus.clr_t, gnt_t);
          gnt   <= '0;
          gnt_t <= '0;
          ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_t     = gnt_t;
  assign bus.q         = q;
  assign bus.q_t       = q_t;
  assign bus.busy      = busy;
  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr;

endmodule
